// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, flag indices, flag-update mask and FSM state encoding
// Imported by alu_arbiter and alu_arbiter_if; no ports.
package alu_arb_pkg;

  // Same encoding as the ALU Opcode input.
  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_SLL    = 4'h3,
    OP_SRA    = 4'h4,
    OP_ROR    = 4'h5,
    OP_RED    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  // Flag vector bit order is {Z,V,N}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN  = 1'b0;
  localparam state_t ST_HALT = 1'b1;

  // Which flag bits an opcode is allowed to write.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] mask;
    mask = 3'b000;
    case (op)
      OP_ADD, OP_SUB: begin
        mask[FLAG_Z] = 1'b1;
        mask[FLAG_V] = 1'b1;
        mask[FLAG_N] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_RED, OP_PADDSB: mask[FLAG_Z] = 1'b1;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response bundle of the ALU arbiter
// slave  : arbiter side (takes requests, drives ALU operands, owns the response slot)
// master : environment side (requesters, ALU, response consumer)
interface alu_arbiter_if #(parameter int DATA_W = 16);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][3:0]        req_op;
  logic [1:0][DATA_W-1:0] req_in1;
  logic [1:0][DATA_W-1:0] req_in2;
  logic [3:0]             alu_op;
  logic [DATA_W-1:0]      alu_in1;
  logic [DATA_W-1:0]      alu_in2;
  logic [2:0]             alu_flags_in;
  logic [DATA_W-1:0]      alu_out;
  logic [2:0]             alu_flags_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [DATA_W-1:0]      rsp_data;
  logic [2:0]             rsp_flags;
  logic                   halted;
  logic                   resume;

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, alu_out, alu_flags_out, rsp_ready, resume,
    output req_ready, alu_op, alu_in1, alu_in2, alu_flags_in,
           rsp_valid, rsp_id, rsp_data, rsp_flags, halted
  );

  modport master (
    output req_valid, req_op, req_in1, req_in2, alu_out, alu_flags_out, rsp_ready, resume,
    input  req_ready, alu_op, alu_in1, alu_in2, alu_flags_in,
           rsp_valid, rsp_id, rsp_data, rsp_flags, halted
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with priority pointer
// clk, rst_n : clock, asynchronous active-low reset
// req        : per-requester request (already qualified)
// gnt        : one-hot-or-zero grant
module rr_arb2 #(
  parameter bit INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr_q names the requester that wins a tie.
  logic ptr_q;

  assign gnt[0] = req[0] & (~req[1] | ~ptr_q);
  assign gnt[1] = req[1] & (~req[0] |  ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= INIT;
    end else if (|gnt) begin
      // Priority passes to whoever was not just served.
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one 16-bit ALU between EX stage (req 0) and debug port (req 1)
// clk, rst_n : clock, asynchronous active-low reset
// bus        : alu_arbiter_if.slave (requests, ALU drive, response slot, halt/resume)
// Optional: ALU_ARB_FIXED_PRIO_EN gives requester 0 strict priority (no RR pointer).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_t            state_q;
  logic [2:0]        flags_q [2];
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [2:0]        rsp_flags_q;

  logic       slot_free;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       grant;
  logic       sel;
  logic [2:0] mask;
  logic [2:0] flags_new;
  logic       hlt_grant;

  // A draining slot can be refilled in the same cycle.
  assign slot_free = ~rsp_valid_q | bus.rsp_ready;
  assign elig[0]   = bus.req_valid[0] & (state_q != ST_HALT) & slot_free;
  assign elig[1]   = bus.req_valid[1] & slot_free;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt = {elig[1] & ~elig[0], elig[0]};
`else
  rr_arb2 #(.INIT(RR_INIT)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (gnt)
  );
`endif

  assign grant = |gnt;
  // No grant selects requester 0 so the ALU inputs are always defined.
  assign sel   = gnt[1];

  assign bus.req_ready    = gnt;
  assign bus.alu_op       = bus.req_op[sel];
  assign bus.alu_in1      = bus.req_in1[sel];
  assign bus.alu_in2      = bus.req_in2[sel];
  assign bus.alu_flags_in = flags_q[sel];

  assign mask      = flag_mask(bus.req_op[sel]);
  assign flags_new = (flags_q[sel] & ~mask) | (bus.alu_flags_out & mask);
  assign hlt_grant = gnt[0] & (bus.req_op[0] == OP_HLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flags_q[0]  <= 3'b000;
      flags_q[1]  <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 3'b000;
    end else begin
      if (grant) begin
        flags_q[sel] <= flags_new;
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= sel;
        rsp_data_q   <= bus.alu_out;
        rsp_flags_q  <= flags_new;
      end else if (bus.rsp_ready) begin
        rsp_valid_q  <= 1'b0;
      end

      // HLT can only be granted in RUN, so it naturally beats a coincident resume.
      if (hlt_grant) begin
        state_q <= ST_HALT;
      end else if (state_q == ST_HALT && bus.resume) begin
        state_q <= ST_RUN;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters: requester 0 is the pipeline EX stage; requester 1 is the debug/scan port.
- The block arbitrates per cycle, drives the ALU operand and opcode ports, and registers the result into a one-entry response slot.
- It owns one architectural ZVN flag register per requester and applies the per-opcode flag-update mask.
- It handles HLT from requester 0 by freezing that requester until it is resumed.

Parameters:
- DATA_W, 16, operand and result width (the ALU is fixed at 16; the parameter exists for the bench).
- RR_INIT, 0, which requester holds round-robin priority out of reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready on a rising clk
- req_op  in  2x4  per-requester opcode (ADD=0 … HLT=F)
- req_in1  in  2xDATA_W  per-requester operand 1
- req_in2  in  2xDATA_W  per-requester operand 2
- alu_op  out  4  to ALU Opcode
- alu_in1  out  DATA_W  to ALU Input1
- alu_in2  out  DATA_W  to ALU Input2
- alu_flags_in  out  3  to ALU flagsIn; the granted requester's flag register
- alu_out  in  DATA_W  from ALU Output
- alu_flags_out  in  3  from ALU flagsOut, bit order {Z,V,N}
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DATA_W  registered ALU result
- rsp_flags  out  3  owner's flag register after this op
- halted  out  1  requester 0 is frozen by HLT
- resume  in  1  single-cycle pulse that leaves HALT

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, both flag registers=0, halted=0, FSM=RUN, RR pointer=RR_INIT.
- Slot free condition: slot_free = !rsp_valid | rsp_ready. With no free slot, req_ready=0 for both requesters (no grant that cycle).
- Eligibility:
  - Requester 0 is eligible when req_valid[0] & !halted.
  - Requester 1 is eligible when req_valid[1].
- Arbitration: round-robin. If both are eligible, the one not granted last wins. After any grant, the RR pointer moves to the other requester. A single eligible requester is always granted.
- Ready timing: req_ready is combinational from valid, halted, RR pointer and slot_free. At most one bit is set.
- ALU drive:
  - alu_op, alu_in1 and alu_in2 are muxed from the granted requester.
  - alu_flags_in is the granted requester's flag register.
  - With no grant, the ALU is driven from requester 0's fields (not a don't-care, for lint stability).
- Latency: one cycle. Grant in cycle N gives rsp_valid=1 in cycle N+1, holding data, id and flags. The slot holds until rsp_ready.
- Back-to-back: a grant is allowed in the same cycle the slot drains (rsp_valid & rsp_ready), giving full throughput of one op per cycle.
- Flag mask (shared package): opcode-indexed 3-bit write mask.
  - ADD and SUB write ZVN.
  - XOR, SLL, SRA, ROR, RED and PADDSB write Z only.
  - LW through HLT write none.
  - Update rule: flags_new = (flags_old & ~mask) | (alu_flags_out & mask), written into the granted requester's register only.
- FSM for requester 0:
  - RUN → HALT when requester 0 is granted with op HLT. HLT still produces a response: data = alu_out, flags unchanged.
  - In HALT: halted=1 and requester 0 is never granted; requester 1 continues to be served.
  - HALT → RUN on resume. resume while in RUN is ignored.
  - If resume arrives in the same cycle as an HLT grant, HLT wins and the FSM stays in HALT.
- Reset mid-operation: a pending response is discarded, the FSM returns to RUN, and the flag registers clear.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- When defined: requester 0 has strict priority over requester 1 and the RR pointer is removed. Requester 1 is granted only when requester 0 is ineligible.
- When undefined: round-robin as specified above.

Decomposition:
- Package alu_arb_pkg holds:
  - the opcode enum (ADD=0 … HLT=F) with the same encoding as the ALU;
  - the FLAG_Z, FLAG_V and FLAG_N bit indices;
  - the flag-mask constant function/table;
  - the state typedef {RUN, HALT}.
- Sub-module: rr_arb2, a 2-way round-robin grant with pointer.

Test Plan:
- Both valid, req0 ADD 0x7fff+0x0001, req1 SUB 0x0001-0x0001, RR=0 → cycle 1 rsp id0 data 0x8000 with flag V set; cycle 2 rsp id1 data 0x0000, flags Z=1; req0 flags untouched by req1's op.
- req0 XOR 0xffff^0xffff after an ADD that set V → rsp data 0x0000, Z=1, V kept at 1 (mask check).
- rsp_ready=0 for 3 cycles with both requesters valid → req_ready=00, rsp_data stable, no grants; ready=1 → drain and new grant in the same cycle.
- req0 HLT → halted=1 next cycle; req0 valid ignored while req1 XORs are served; resume pulse → req0 granted on the following arbitration.
- HLT grant and resume in the same cycle → stays in HALT.
- rst_n asserted low with rsp_valid=1 and HALT active → rsp_valid=0, halted=0 and flags=000 immediately, without waiting for a clock edge.
